// File: rtl/nand_seq_pkg.sv
// Shared encodings and timing helpers for the asynchronous NAND command sequencer.
package nand_seq_pkg;

   typedef enum logic [1:0] {
      OP_CMD  = 2'd0,
      OP_ADDR = 2'd1,
      OP_READ = 2'd2,
      OP_NOP  = 2'd3
   } op_e;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_SETUP = 4'd1,
      ST_WE_LO = 4'd2,
      ST_WE_HI = 4'd3,
      ST_RE_LO = 4'd4,
      ST_RE_HI = 4'd5
   } state_e;

   function automatic int unsigned tclamp(input int unsigned t);
      return (t == 0) ? 1 : t;
   endfunction

   // Timer reload for a state lasting 'cycles', minus 'skip' cycles spent elsewhere.
   function automatic logic [3:0] tload(input int unsigned cycles, input int unsigned skip);
      return (cycles > skip) ? 4'(cycles - 1 - skip) : 4'd0;
   endfunction

endpackage

// File: rtl/nand_seq_timer.sv
// Loadable 4-bit down-counter; done is high while the count sits at zero.
module nand_seq_timer (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [3:0] val_i,
   output logic       done_o
);

   logic [3:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= 4'd0;
      end else if (load_i) begin
         cnt_q <= val_i;
      end else if (cnt_q != 4'd0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/nand_async_cmd_seq.sv
// Asynchronous-mode NAND pin sequencer: one CMD/ADDR/READ/NOP per handshake,
// generating CLE/ALE/CE#/WE#/RE# with programmable cycle counts.
module nand_async_cmd_seq
   import nand_seq_pkg::*;
#(
   parameter int unsigned T_SETUP  = 2,
   parameter int unsigned T_WP     = 3,
   parameter int unsigned T_WH     = 2,
   parameter int unsigned T_RP     = 3,
   parameter int unsigned T_REH    = 2,
   parameter int unsigned DQ_WIDTH = 8
) (
   input  logic                v_clk0,
   input  logic                v_rstn0,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic [DQ_WIDTH-1:0] req_byte,
   input  logic [1:0]          req_cen,
   input  logic                req_last,
   input  logic                cfg_wp_n,
   output logic                rsp_valid,
   output logic [DQ_WIDTH-1:0] rsp_data,
   output logic                v_ctrl_cle,
   output logic                v_ctrl_ale,
   output logic                v_ctrl_wrn,
   output logic                v_ctrl_wpn,
   output logic [1:0]          v_ctrl_cen,
   output logic                v_ctrl_wen,
   output logic                v_ctrl_wen_sel,
   output logic                v_dq_oe_n,
   output logic [DQ_WIDTH-1:0] v_wr_data_rise,
   output logic [DQ_WIDTH-1:0] v_wr_data_fall,
   input  logic [DQ_WIDTH-1:0] v_rd_data_comb,
   output logic [7:0]          v_ctrl_debug
);

   // The IDLE-entry cycle serves as the final WE#/RE# high-hold cycle, so the
   // hold states themselves last one cycle less than the programmed count.
   localparam logic [3:0] LD_SETUP = tload(tclamp(T_SETUP), 0);
   localparam logic [3:0] LD_WP    = tload(tclamp(T_WP), 0);
   localparam logic [3:0] LD_WH    = tload(tclamp(T_WH), 1);
   localparam logic [3:0] LD_RP    = tload(tclamp(T_RP), 0);
   localparam logic [3:0] LD_REH   = tload(tclamp(T_REH), 1);
   localparam bit         HAS_WH   = (tclamp(T_WH) > 1);
   localparam bit         HAS_REH  = (tclamp(T_REH) > 1);

   state_e                state_q;
   op_e                   op_q;
   logic                  ready_q, last_q, ce_held_q;
   logic                  cle_q, ale_q, wrn_q, wen_q, wpn_q, dq_oe_n_q;
   logic [1:0]            cen_q;
   logic [DQ_WIDTH-1:0]   wr_data_q, rsp_data_q;
   logic                  rsp_valid_q;

   logic                  accept;
   logic                  tmr_done;
   logic                  tmr_load_d;
   logic [3:0]            tmr_val_d;
   logic                  to_idle_d;

   assign accept = req_valid && ready_q && (state_q == ST_IDLE);

   always_comb begin
      tmr_load_d = 1'b0;
      tmr_val_d  = 4'd0;
      to_idle_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept && (req_op != OP_NOP)) begin
               tmr_load_d = 1'b1;
               tmr_val_d  = LD_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_done) begin
               tmr_load_d = 1'b1;
               tmr_val_d  = (op_q == OP_READ) ? LD_RP : LD_WP;
            end
         end
         ST_WE_LO: begin
            tmr_load_d = tmr_done;
            tmr_val_d  = LD_WH;
            to_idle_d  = tmr_done && !HAS_WH;
         end
         ST_RE_LO: begin
            tmr_load_d = tmr_done;
            tmr_val_d  = LD_REH;
            to_idle_d  = tmr_done && !HAS_REH;
         end
         ST_WE_HI, ST_RE_HI: to_idle_d = tmr_done;
         default: ;
      endcase
   end

   nand_seq_timer u_timer (
      .clk_i  (v_clk0),
      .rst_ni (v_rstn0),
      .load_i (tmr_load_d),
      .val_i  (tmr_val_d),
      .done_o (tmr_done)
   );

   always_ff @(posedge v_clk0 or negedge v_rstn0) begin
      if (!v_rstn0) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NOP;
         ready_q     <= 1'b1;
         last_q      <= 1'b0;
         ce_held_q   <= 1'b0;
         cle_q       <= 1'b0;
         ale_q       <= 1'b0;
         wrn_q       <= 1'b1;
         wen_q       <= 1'b1;
         wpn_q       <= 1'b0;
         dq_oe_n_q   <= 1'b1;
         cen_q       <= 2'b11;
         wr_data_q   <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         wpn_q       <= cfg_wp_n;
         rsp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q <= op_e'(req_op);
                  if (req_op == OP_NOP) begin
                     cen_q     <= 2'b11;
                     ce_held_q <= 1'b0;
                  end else begin
                     // A held CE# switches straight to the new target, never via 11.
                     cen_q     <= req_cen;
                     cle_q     <= (req_op == OP_CMD);
                     ale_q     <= (req_op == OP_ADDR);
                     dq_oe_n_q <= !((req_op == OP_CMD) || (req_op == OP_ADDR));
                     wr_data_q <= req_byte;
                     last_q    <= req_last;
                     ready_q   <= 1'b0;
                     state_q   <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: begin
               if (tmr_done) begin
                  if (op_q == OP_READ) begin
                     wrn_q   <= 1'b0;
                     state_q <= ST_RE_LO;
                  end else begin
                     wen_q   <= 1'b0;
                     state_q <= ST_WE_LO;
                  end
               end
            end
            ST_WE_LO: begin
               if (tmr_done) begin
                  wen_q   <= 1'b1;
                  state_q <= ST_WE_HI;
               end
            end
            ST_RE_LO: begin
               if (tmr_done) begin
                  wrn_q       <= 1'b1;
                  rsp_data_q  <= v_rd_data_comb;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RE_HI;
               end
            end
            ST_WE_HI, ST_RE_HI: ;
            default: state_q <= ST_IDLE;
         endcase
         if (to_idle_d) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            cle_q     <= 1'b0;
            ale_q     <= 1'b0;
            dq_oe_n_q <= 1'b1;
            if (last_q) begin
               cen_q     <= 2'b11;
               ce_held_q <= 1'b0;
            end else begin
               ce_held_q <= 1'b1;
            end
         end
      end
   end

   assign req_ready      = ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign v_ctrl_cle     = cle_q;
   assign v_ctrl_ale     = ale_q;
   assign v_ctrl_wrn     = wrn_q;
   assign v_ctrl_wpn     = wpn_q;
   assign v_ctrl_cen     = cen_q;
   assign v_ctrl_wen     = wen_q;
   assign v_ctrl_wen_sel = 1'b1;
   assign v_dq_oe_n      = dq_oe_n_q;
   assign v_wr_data_rise = wr_data_q;
   assign v_wr_data_fall = wr_data_q;
   assign v_ctrl_debug   = {state_q, op_q, ce_held_q, rsp_valid_q};

endmodule
